uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_framer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
// Receives 8N1 serial frames (LSB first, idle high) on an asynchronous line
// and presents each completed byte to the system clock domain.
//
// Valid/ready note: this block has no back-pressure. rx_valid is a one-cycle
// strobe with no ready input, and the consumer must take rx_data on that
// cycle or later, before the next frame completes. rx_data holds its value
// between frames.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line bit rate; BIT_CYC = CLK_HZ/BAUD must be >= 16
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rs232_rx   asynchronous serial input line
//   rx_data    last received byte, updated only when a frame completes
//   rx_int     high from start-edge detection until the end of the frame
//   rx_valid   one-cycle pulse for a frame with a good stop bit
//   frame_err  set by a frame whose stop bit is 0, cleared by the next good frame
module uart_rx_framer #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;     // rxs
    logic             rxs_d_q, rxs_d_d;     // rxs delayed by one clock
    logic [2:0]       vote_q, vote_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_int_q, rx_int_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             vote;

    // Two of the last three synchronized samples decide each bit, so a
    // single-clock glitch on the line can never flip a decision.
    assign vote = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) |
                  (vote_q[1] & vote_q[2]);

    always_comb begin
        sync1_d     = rs232_rx;
        sync2_d     = sync1_q;
        rxs_d_d     = sync2_q;
        vote_d      = {vote_q[1:0], sync2_q};
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_int_d    = rx_int_q;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err_q;

        case (state_q)
            IDLE: begin
                // Only a fresh 1->0 edge starts a frame; a line held low
                // (break) stays here.
                if (rxs_d_q && !sync2_q) begin
                    state_d  = START;
                    cnt_d    = '0;
                    rx_int_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!vote) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_d  = IDLE;
                        rx_int_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = vote;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    rx_int_d  = 1'b0;
                    rx_data_d = shift_q;
                    if (vote) begin
                        rx_valid_d  = 1'b1;
                        frame_err_d = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rxs_d_q     <= 1'b1;
            vote_q      <= 3'b111;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_int_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rxs_d_q     <= rxs_d_d;
            vote_q      <= vote_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_int_q    <= rx_int_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_int    = rx_int_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed serial frames, a frame-level expected
// queue and a per-cycle compare process.
module tb_uart_rx_framer;

    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 115200;
    localparam int B      = CLK_HZ / BAUD;   // 434
    localparam int HALF   = B / 2;           // 217
    localparam int LAT    = HALF + 9 * B + 1;

    localparam logic [1:0] K_GOOD   = 2'd0;
    localparam logic [1:0] K_BAD    = 2'd1;
    localparam logic [1:0] K_GLITCH = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       rx_valid;
    logic       frame_err;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // {kind, data, start cycle}
    logic [41:0] exp_q[$];
    int          valid_cyc[$];

    uart_rx_framer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_int    (rx_int),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] d, input logic stop, input logic glitch);
        exp_q.push_back({(stop ? K_GOOD : K_BAD), d, 32'(cyc)});
        rs232_rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < B; c++) begin
                rs232_rx = (glitch && c == HALF) ? ~d[i] : d[i];
                @(negedge clk);
            end
        end
        rs232_rx = stop;
        repeat (B) @(negedge clk);
    endtask

    task automatic idle_line(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 4 * B && exp_q.size() != 0; i++) @(negedge clk);
        check("frames_drained", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard / compare process ----------------
    initial begin : compare
        logic        prev_int;
        logic [7:0]  m_data;
        logic        m_err;
        int          rise_cyc;
        logic [41:0] e;
        prev_int = 1'b0;
        m_data   = 8'h00;
        m_err    = 1'b0;
        rise_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("rst_rx_data", rx_data, 8'h00);
                check("rst_rx_int", rx_int, 1'b0);
                check("rst_rx_valid", rx_valid, 1'b0);
                check("rst_frame_err", frame_err, 1'b0);
                exp_q.delete();
                m_data   = 8'h00;
                m_err    = 1'b0;
                prev_int = 1'b0;
            end else begin
                if (rx_int === 1'b1 && prev_int === 1'b0) rise_cyc = cyc;
                if (prev_int === 1'b1 && rx_int === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        case (e[41:40])
                            K_GOOD: begin
                                m_data = e[39:32];
                                m_err  = 1'b0;
                                check("valid_at_end", rx_valid, 1'b1);
                                check_range("latency", cyc - int'(e[31:0]) - 2, LAT - 2, LAT + 2);
                                check_range("rx_int_width", cyc - rise_cyc, 3, 10 * B);
                                valid_cyc.push_back(cyc);
                            end
                            K_BAD: begin
                                m_data = e[39:32];
                                m_err  = 1'b1;
                                check("no_valid_bad_stop", rx_valid, 1'b0);
                                check_range("latency_bad", cyc - int'(e[31:0]) - 2, LAT - 2, LAT + 2);
                            end
                            default: begin
                                check("no_valid_glitch", rx_valid, 1'b0);
                                check_range("glitch_int_width", cyc - rise_cyc, HALF, 100 + HALF + 2);
                            end
                        endcase
                    end
                end else begin
                    check("rx_valid_idle", rx_valid, 1'b0);
                end
                check("rx_data", rx_data, m_data);
                check("frame_err", frame_err, m_err);
                prev_int = rx_int;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        repeat (3) @(negedge clk);
        check("init_rx_data", rx_data, 8'h00);
        check("init_rx_int", rx_int, 1'b0);
        rst = 1'b0;
        idle_line(20);

        // single good byte
        send_byte(8'h55, 1'b1, 1'b0);
        wait_drained();
        check("lit_55_data", rx_data, 8'h55);
        check("lit_55_err", frame_err, 1'b0);
        idle_line(B);

        // back-to-back frames
        send_byte(8'hA3, 1'b1, 1'b0);
        send_byte(8'h0F, 1'b1, 1'b0);
        wait_drained();
        check("lit_0f_data", rx_data, 8'h0F);
        check_range("b2b_gap", valid_cyc[valid_cyc.size() - 1] - valid_cyc[valid_cyc.size() - 2],
                    10 * B - 2, 10 * B + 2);
        idle_line(B);

        // 100-clock low pulse in idle
        exp_q.push_back({K_GLITCH, 8'h00, 32'(cyc)});
        rs232_rx = 1'b0;
        repeat (100) @(negedge clk);
        idle_line(2 * B);
        wait_drained();
        check("lit_after_pulse", rx_data, 8'h0F);

        // bad stop bit followed by a break
        send_byte(8'h3C, 1'b0, 1'b0);
        rs232_rx = 1'b0;
        repeat (20 * B) @(negedge clk);
        wait_drained();
        check("lit_3c_data", rx_data, 8'h3C);
        check("lit_3c_err", frame_err, 1'b1);
        idle_line(2 * B);
        send_byte(8'h81, 1'b1, 1'b0);
        wait_drained();
        check("lit_81_data", rx_data, 8'h81);
        check("lit_81_err", frame_err, 1'b0);
        idle_line(B);

        // another bad frame so reset has non-zero state to clear
        send_byte(8'h5A, 1'b0, 1'b0);
        idle_line(B);
        wait_drained();
        check("lit_5a_err", frame_err, 1'b1);

        // reset during data bit 4 of 0xFF
        exp_q.push_back({K_GOOD, 8'hFF, 32'(cyc)});
        rs232_rx = 1'b0;
        repeat (B) @(negedge clk);
        rs232_rx = 1'b1;
        repeat (4 * B + HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_line(2 * B);
        check("lit_rst_data", rx_data, 8'h00);
        check("lit_rst_err", frame_err, 1'b0);
        check("lit_rst_int", rx_int, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        wait_drained();
        check("lit_12_data", rx_data, 8'h12);
        idle_line(B);

        // one-clock glitches at mid-bit of every data bit
        send_byte(8'h00, 1'b1, 1'b1);
        wait_drained();
        check("lit_glitch_data", rx_data, 8'h00);
        check("lit_glitch_err", frame_err, 1'b0);
        idle_line(B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
